// File: rtl/vga_scan_ctrl.sv
// VGA raster timing generator. Drives the compositor read coordinates and emits
// syncs, active flag and blank-gated RGB aligned to the compositor latency, plus a frame tick.
module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_LAT = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] o_x_read,
  output logic [10:0] o_y_read,
  input  logic [3:0]  i_r,
  input  logic [3:0]  i_g,
  input  logic [3:0]  i_b,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_active,
  output logic        o_frame_tick
);

  localparam int unsigned CW       = 11;
  localparam int unsigned RGBW     = 12;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  // One extra stage so the final flags line up with the registered RGB.
  localparam int unsigned DW       = PIPE_LAT + 1;

  logic [CW-1:0]   h_cnt_q, h_cnt_d;
  logic [CW-1:0]   v_cnt_q, v_cnt_d;
  logic [DW-1:0]   act_q, act_d;
  logic [DW-1:0]   hs_q, hs_d;
  logic [DW-1:0]   vs_q, vs_d;
  logic [RGBW-1:0] rgb_q, rgb_d;
  logic            tick_q, tick_d;
  logic            h_wrap;
  logic            act_raw;
  logic            hs_raw;
  logic            vs_raw;

  // Counters, raw timing flags and next-state for the delay chains.
  always_comb begin
    h_wrap  = (h_cnt_q == CW'(H_TOTAL - 1));
    h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == CW'(V_TOTAL - 1)) ? '0 : v_cnt_q + CW'(1);
    end

    act_raw = (h_cnt_q < CW'(H_ACTIVE)) && (v_cnt_q < CW'(V_ACTIVE));
    hs_raw  = (h_cnt_q >= CW'(HS_START)) && (h_cnt_q < CW'(HS_END));
    vs_raw  = (v_cnt_q >= CW'(VS_START)) && (v_cnt_q < CW'(VS_END));

    // Sync chains carry pin levels so the last stage drives the pin directly.
    act_d  = {act_q[DW-2:0], act_raw};
    hs_d   = {hs_q[DW-2:0], hs_raw ? SYNC_POL : ~SYNC_POL};
    vs_d   = {vs_q[DW-2:0], vs_raw ? SYNC_POL : ~SYNC_POL};

    // Compositor output now belongs to the coordinate whose flag sits in stage DW-2.
    rgb_d  = act_q[DW-2] ? {i_r, i_g, i_b} : RGBW'(0);
    tick_d = (h_cnt_q == '0) && (v_cnt_q == CW'(V_ACTIVE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      act_q   <= '0;
      hs_q    <= {DW{~SYNC_POL}};
      vs_q    <= {DW{~SYNC_POL}};
      rgb_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      act_q   <= act_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      tick_q  <= tick_d;
    end
  end

  assign o_x_read     = h_cnt_q;
  assign o_y_read     = v_cnt_q;
  assign o_active     = act_q[DW-1];
  assign o_hsync      = hs_q[DW-1];
  assign o_vsync      = vs_q[DW-1];
  assign o_r          = rgb_q[11:8];
  assign o_g          = rgb_q[7:4];
  assign o_b          = rgb_q[3:0];
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: default line timing with a short frame
// (16 active lines, 31 total) so whole frames fit in a short run.
module tb_vga_scan_ctrl;

  localparam int unsigned H_SYNC_W = 96;
  localparam int unsigned V_SYNC_W = 2 * 800;

  typedef struct {
    int          cyc;
    logic [10:0] x;
    logic [10:0] y;
  } xy_t;

  typedef struct {
    int          cyc;
    logic        act;
    logic [11:0] rgb;
  } px_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] o_x_read, o_y_read;
  logic [3:0]  i_r, i_g, i_b;
  logic        o_hsync, o_vsync, o_active, o_frame_tick;
  logic [3:0]  o_r, o_g, o_b;
  logic [11:0] comp_s1, comp_s2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_seen = 1'b0;

  xy_t q_xy[$];
  px_t q_px[$];
  int  q_hs[$];
  int  q_vs[$];
  int  q_tick[$];

  vga_scan_ctrl #(
    .V_ACTIVE(16), .V_FP(10), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk(clk), .rst(rst),
    .o_x_read(o_x_read), .o_y_read(o_y_read),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_active(o_active), .o_frame_tick(o_frame_tick)
  );

  always #5 clk = ~clk;

  // Compositor model: RGB = {y[3:0], x[7:0]} two clocks after the coordinate.
  always @(posedge clk) begin
    comp_s1 <= {o_y_read[3:0], o_x_read[7:0]};
    comp_s2 <= comp_s1;
  end
  assign i_r = comp_s2[11:8];
  assign i_g = comp_s2[7:4];
  assign i_b = comp_s2[3:0];

  // cyc = index of the current clock since reset release (counters equal cyc at start).
  always @(posedge clk) begin
    rst_seen <= rst;
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_xy(input int c, input int x, input int y);
    xy_t e;
    e.cyc = c; e.x = 11'(x); e.y = 11'(y);
    q_xy.push_back(e);
  endtask

  task automatic push_px(input int c, input logic a, input logic [11:0] rgb);
    px_t e;
    e.cyc = c; e.act = a; e.rgb = rgb;
    q_px.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents a matching event.
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;
  int   hs_fall_cyc = 0;
  int   vs_fall_cyc = 0;
  always @(negedge clk) begin : monitor
    xy_t ex;
    px_t ep;
    if (rst_seen) begin
      chk("rst_hsync", 32'(o_hsync), 32'd1);
      chk("rst_vsync", 32'(o_vsync), 32'd1);
      chk("rst_rgb", 32'({o_r, o_g, o_b}), 32'h000);
      chk("rst_active", 32'(o_active), 32'd0);
      chk("rst_tick", 32'(o_frame_tick), 32'd0);
    end
    if (q_xy.size() > 0 && q_xy[0].cyc == cyc) begin
      ex = q_xy.pop_front();
      chk("x_read", 32'(o_x_read), 32'(ex.x));
      chk("y_read", 32'(o_y_read), 32'(ex.y));
    end
    if (q_px.size() > 0 && q_px[0].cyc == cyc) begin
      ep = q_px.pop_front();
      chk("px_active", 32'(o_active), 32'(ep.act));
      chk("px_rgb", 32'({o_r, o_g, o_b}), 32'(ep.rgb));
    end
    if (!rst && !rst_seen) begin
      if (prev_hs && !o_hsync) begin
        if (q_hs.size() == 0) chk("hs_fall_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else                  chk("hs_fall", 32'(cyc), 32'(q_hs.pop_front()));
        hs_fall_cyc = cyc;
      end
      if (!prev_hs && o_hsync) chk("hs_width", 32'(cyc - hs_fall_cyc), 32'(H_SYNC_W));
      if (prev_vs && !o_vsync) begin
        if (q_vs.size() == 0) chk("vs_fall_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else                  chk("vs_fall", 32'(cyc), 32'(q_vs.pop_front()));
        vs_fall_cyc = cyc;
      end
      if (!prev_vs && o_vsync) chk("vs_width", 32'(cyc - vs_fall_cyc), 32'(V_SYNC_W));
      if (o_frame_tick) begin
        if (q_tick.size() == 0) chk("tick_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else                    chk("frame_tick", 32'(cyc), 32'(q_tick.pop_front()));
      end
    end
    prev_hs = o_hsync;
    prev_vs = o_vsync;
  end

  // Frame is 800 x 31 = 24800 clocks; pin events land 3 clocks after the raw counter state.
  initial begin
    push_xy(0, 0, 0);
    push_xy(8799, 799, 10);
    push_xy(8800, 0, 11);
    push_xy(24799, 799, 30);
    push_xy(24800, 0, 0);
    push_xy(53900, 300, 5);
    push_px(2, 1'b0, 12'h000);
    push_px(3, 1'b1, 12'h000);
    push_px(8, 1'b1, 12'h005);
    push_px(642, 1'b1, 12'h07F);
    push_px(643, 1'b0, 12'h000);
    push_px(802, 1'b0, 12'h000);
    push_px(803, 1'b1, 12'h100);
    push_px(1058, 1'b1, 12'h1FF);
    push_px(5903, 1'b1, 12'h72C);
    push_px(12642, 1'b1, 12'hF7F);
    push_px(12803, 1'b0, 12'h000);
    push_px(16103, 1'b0, 12'h000);
    push_px(24803, 1'b1, 12'h000);
    push_px(24804, 1'b1, 12'h001);
    for (int k = 0; k <= 66; k++) q_hs.push_back(659 + 800 * k);
    q_vs.push_back(20803);
    q_vs.push_back(45603);
    q_tick.push_back(12801);
    q_tick.push_back(37601);

    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    // Reset lands while the counters sit at (300,5) in the third frame.
    repeat (53900) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    chk("runA_xy_left", 32'(q_xy.size()), 32'd0);
    chk("runA_px_left", 32'(q_px.size()), 32'd0);
    chk("runA_hs_left", 32'(q_hs.size()), 32'd0);
    chk("runA_vs_left", 32'(q_vs.size()), 32'd0);
    chk("runA_tick_left", 32'(q_tick.size()), 32'd0);
    q_xy.delete(); q_px.delete(); q_hs.delete(); q_vs.delete(); q_tick.delete();

    push_xy(0, 0, 0);
    push_xy(1, 1, 0);
    push_px(2, 1'b0, 12'h000);
    push_px(3, 1'b1, 12'h000);
    push_px(4, 1'b1, 12'h001);
    for (int k = 0; k <= 27; k++) q_hs.push_back(659 + 800 * k);
    q_vs.push_back(20803);
    q_tick.push_back(12801);

    repeat (22500) @(posedge clk);
    @(negedge clk);
    #1;
    chk("runB_xy_left", 32'(q_xy.size()), 32'd0);
    chk("runB_px_left", 32'(q_px.size()), 32'd0);
    chk("runB_hs_left", 32'(q_hs.size()), 32'd0);
    chk("runB_vs_left", 32'(q_vs.size()), 32'd0);
    chk("runB_tick_left", 32'(q_tick.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
